// File: rtl/camera_ctrl.sv
// Camera capture sequencer: idle/erase, exposure-timer setup, expose, and a two-row readout.
// Define CAMERA_CTRL_CONTINUOUS_EN to make init level-sensitive with back-to-back captures.
module camera_ctrl #(
    parameter logic [4:0] EXP_MIN     = 5'd2,
    parameter logic [4:0] EXP_MAX     = 5'd30,
    parameter logic [4:0] EXP_DEFAULT = 5'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       exp_increase,
    input  logic       exp_decrease,
    input  logic       ex_done,
    output logic       ex_set,
    output logic       ex_start,
    output logic [4:0] ex_time,
    output logic       erase,
    output logic       expose,
    output logic       nre_1,
    output logic       nre_2,
    output logic       adc
);

    typedef enum logic [1:0] {IDLE, SETUP, EXPOSE, READOUT} state_t;

    state_t     state;
    logic [2:0] k;
    logic       init_q, inc_q, dec_q;
    logic       trigger, chain, inc_edge, dec_edge;

`ifdef CAMERA_CTRL_CONTINUOUS_EN
    assign trigger = init;
    assign chain   = init;
`else
    assign trigger = init & ~init_q;
    assign chain   = 1'b0;
`endif

    assign inc_edge = exp_increase & ~inc_q;
    assign dec_edge = exp_decrease & ~dec_q;

    // Outputs are written alongside the transition so they always match the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= 3'd0;
            ex_time  <= EXP_DEFAULT;
            init_q   <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            ex_set   <= 1'b0;
            ex_start <= 1'b0;
            erase    <= 1'b1;
            expose   <= 1'b0;
            nre_1    <= 1'b1;
            nre_2    <= 1'b1;
            adc      <= 1'b0;
        end else begin
            init_q <= init;
            inc_q  <= exp_increase;
            dec_q  <= exp_decrease;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state  <= SETUP;
                        ex_set <= 1'b1;
                        erase  <= 1'b0;
                    end else if (inc_edge && !dec_edge) begin
                        if (ex_time < EXP_MAX) ex_time <= ex_time + 5'd1;
                    end else if (dec_edge && !inc_edge) begin
                        if (ex_time > EXP_MIN) ex_time <= ex_time - 5'd1;
                    end
                end
                SETUP: begin
                    state    <= EXPOSE;
                    ex_set   <= 1'b0;
                    ex_start <= 1'b1;
                    expose   <= 1'b1;
                end
                EXPOSE: begin
                    if (ex_done) begin
                        state    <= READOUT;
                        k        <= 3'd0;
                        ex_start <= 1'b0;
                        expose   <= 1'b0;
                        nre_1    <= 1'b0;
                    end
                end
                READOUT: begin
                    // Each arm sets up the outputs for subcounter value k+1.
                    k <= k + 3'd1;
                    case (k)
                        3'd0: adc   <= 1'b1;
                        3'd1: adc   <= 1'b0;
                        3'd2: nre_1 <= 1'b1;
                        3'd3: nre_2 <= 1'b0;
                        3'd4: adc   <= 1'b1;
                        3'd5: adc   <= 1'b0;
                        3'd6: nre_2 <= 1'b1;
                        default: begin
                            if (chain) begin
                                state  <= SETUP;
                                ex_set <= 1'b1;
                            end else begin
                                state <= IDLE;
                                erase <= 1'b1;
                            end
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_ctrl.sv
// Scoreboard bench for camera_ctrl: a capture-sequence model predicts every output cycle.
module tb_camera_ctrl;

`ifdef CAMERA_CTRL_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif
    localparam int EMIN = 2, EMAX = 30, EDEF = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1, init = 1'b0, exp_increase = 1'b0, exp_decrease = 1'b0;
    logic       ex_done;
    logic       ex_set, ex_start, erase, expose, nre_1, nre_2, adc;
    logic [4:0] ex_time;

    camera_ctrl dut (
        .clk(clk), .reset(reset), .init(init), .exp_increase(exp_increase),
        .exp_decrease(exp_decrease), .ex_done(ex_done), .ex_set(ex_set),
        .ex_start(ex_start), .ex_time(ex_time), .erase(erase), .expose(expose),
        .nre_1(nre_1), .nre_2(nre_2), .adc(adc)
    );

    always #5 clk = ~clk;

    // Exposure timer attached to the controller: load on ex_set, count down on ex_start.
    logic [4:0] tcnt = 5'd0;
    always @(posedge clk) begin
        if (ex_set) tcnt <= ex_time;
        else if (ex_start && tcnt != 5'd0) tcnt <= tcnt - 5'd1;
    end
    assign ex_done = ex_start && (tcnt == 5'd0);

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got set=%b start=%b time=%0d erase=%b expose=%b nre1=%b nre2=%b adc=%b, required set=%b start=%b time=%0d erase=%b expose=%b nre1=%b nre2=%b adc=%b",
                     name, $time, act[11], act[10], act[9:5], act[4], act[3], act[2], act[1], act[0],
                     exp[11], exp[10], exp[9:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Reference model: a capture is a fixed list of output vectors generated up front.
    logic [11:0] pend[$];
    logic [11:0] sb[$];
    bit          m_idle = 1'b1;
    int          m_time = EDEF;
    bit          pi = 1'b0, pu = 1'b0, pd = 1'b0;

    function automatic logic [11:0] vec(bit s, bit st, int t, bit er, bit ex, bit n1, bit n2, bit a);
        logic [4:0] t5;
        t5 = t[4:0];
        return {s, st, t5, er, ex, n1, n2, a};
    endfunction

    task automatic build_capture();
        pend.push_back(vec(1, 0, m_time, 0, 0, 1, 1, 0));
        for (int c = 0; c < m_time + 1; c++) pend.push_back(vec(0, 1, m_time, 0, 1, 1, 1, 0));
        for (int kk = 0; kk < 8; kk++)
            pend.push_back(vec(0, 0, m_time, 0, 0, !(kk <= 2), !(kk >= 4 && kk <= 6),
                               (kk == 1 || kk == 5)));
    endtask

    task automatic model(input bit r, input bit i, input bit u, input bit d);
        logic [11:0] e;
        bit trig, ue, de;
        if (r) begin
            pend.delete();
            m_idle = 1'b1;
            m_time = EDEF;
            e = vec(0, 0, m_time, 1, 0, 1, 1, 0);
            pi = 0; pu = 0; pd = 0;
        end else begin
            if (m_idle) begin
                trig = CONT ? i : (i && !pi);
                if (trig) begin
                    build_capture();
                    m_idle = 1'b0;
                    e = pend.pop_front();
                end else begin
                    ue = u && !pu;
                    de = d && !pd;
                    if (ue && !de) m_time = (m_time + 1 > EMAX) ? EMAX : m_time + 1;
                    if (de && !ue) m_time = (m_time - 1 < EMIN) ? EMIN : m_time - 1;
                    e = vec(0, 0, m_time, 1, 0, 1, 1, 0);
                end
            end else if (pend.size() > 0) begin
                e = pend.pop_front();
            end else if (CONT && i) begin
                build_capture();
                e = pend.pop_front();
            end else begin
                m_idle = 1'b1;
                e = vec(0, 0, m_time, 1, 0, 1, 1, 0);
            end
            pi = i; pu = u; pd = d;
        end
        sb.push_back(e);
    endtask

    task automatic step(input bit r, input bit i, input bit u, input bit d);
        reset = r; init = i; exp_increase = u; exp_decrease = d;
        @(posedge clk);
        model(r, i, u, d);
        #1;
    endtask

    // Monitor: the DUT presents a fresh output vector every cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [11:0] e;
            e = sb.pop_front();
            chk("outputs", {ex_set, ex_start, ex_time, erase, expose, nre_1, nre_2, adc}, e);
        end
    end

    initial begin
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // Three increment pulses: 10 -> 13
        for (int p = 0; p < 3; p++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        @(negedge clk);
        chk("ex_time_13", {7'd0, ex_time}, 12'd13);
        for (int p = 0; p < 25; p++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
        for (int p = 0; p < 40; p++) begin step(0, 0, 0, 1); step(0, 0, 0, 0); end
        // Full capture at the default exposure
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int c = 0; c < 25; c++) step(0, 0, 0, 0);
        // Reset during the fourth exposure cycle
        step(0, 1, 0, 0);
        for (int c = 0; c < 4; c++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        // init held high across a whole capture
        for (int c = 0; c < 45; c++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int c = 0; c < 45; c++) step(0, 0, 0, 0);
        // Simultaneous edges, and an increment during exposure
        step(0, 0, 1, 1); step(0, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 0, 0);
        for (int c = 0; c < 30; c++) step(0, 0, 0, 0);
        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", {11'd0, sb.size() != 0}, 12'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
